// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Used by int_ctrl, prio_enc and int_ctrl_if.
package int_ctrl_pkg;

    localparam int IC_VEC_W = 3;
    localparam logic [31:0] IC_VEC_BASE = 32'h0000_0100;
    localparam logic [31:0] IC_VEC_STRIDE = 32'h0000_0008;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_REQ,
        IC_BUSY
    } ic_state_e;

    function automatic logic [31:0] ic_vec_addr(
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [IC_VEC_W-1:0] vec
    );
        return base + 32'(vec) * stride;
    endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bundle between the interrupt pins / cp0 side and int_ctrl.
// master = cp0/pin side, slave = the controller.
interface int_ctrl_if
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0]  hw_int;
    logic                mask_we;
    logic [NUM_SRC-1:0]  mask_wdata;
    logic                take;
    logic                eret;
    logic                int_req;
    logic [IC_VEC_W-1:0] int_vec;
    logic [31:0]         int_addr;
    logic [NUM_SRC-1:0]  mask;
    logic [NUM_SRC-1:0]  in_service;
    logic [NUM_SRC-1:0]  pending;

    modport master (
        output hw_int, mask_we, mask_wdata, take, eret,
        input  int_req, int_vec, int_addr, mask, in_service, pending
    );

    modport slave (
        input  hw_int, mask_we, mask_wdata, take, eret,
        output int_req, int_vec, int_addr, mask, in_service, pending
    );
endinterface

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: valid bit plus winning index.
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]        req_i,
    output logic                valid_o,
    output logic [IC_VEC_W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IC_VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge latch, mask, fixed priority, in-service.
// Define INT_CTRL_NEST_EN to let higher-priority sources preempt a handler.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = IC_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = IC_VEC_STRIDE
) (
    input logic        clk,
    input logic        clr_n,
    int_ctrl_if.slave  bus
);

    logic [NUM_SRC-1:0]  hw_prev_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  mask_q, mask_d;
    logic [NUM_SRC-1:0]  isv_q, isv_d;
    logic                int_req_q, int_req_d;
    logic [IC_VEC_W-1:0] int_vec_q, int_vec_d;
    logic [31:0]         int_addr_q, int_addr_d;
    ic_state_e           state_q, state_d;

    logic [NUM_SRC-1:0]  cand, eligible, rise, take_oh, eret_oh;
    logic                elig_v, isv_v, take_ok, eret_ok;
    logic [IC_VEC_W-1:0] elig_idx, isv_idx;

    prio_enc #(.W(NUM_SRC)) u_elig_enc (
        .req_i   (eligible),
        .valid_o (elig_v),
        .idx_o   (elig_idx)
    );

    prio_enc #(.W(NUM_SRC)) u_isv_enc (
        .req_i   (isv_q),
        .valid_o (isv_v),
        .idx_o   (isv_idx)
    );

    assign cand = pending_q & mask_q;

`ifdef INT_CTRL_NEST_EN
    logic [NUM_SRC-1:0] above;
    // Only sources strictly above the active service level may preempt.
    assign above = (NUM_SRC'(1) << isv_idx) - NUM_SRC'(1);
    assign eligible = isv_v ? (cand & above) : cand;
`else
    assign eligible = isv_v ? '0 : cand;
`endif

    always_comb begin
        rise    = bus.hw_int & ~hw_prev_q;
        take_ok = bus.take & int_req_q;
        eret_ok = bus.eret & isv_v;
        eret_oh = eret_ok ? (NUM_SRC'(1) << isv_idx) : '0;
        take_oh = take_ok ? (NUM_SRC'(1) << int_vec_q) : '0;
        // Eret retires first; a same-cycle rise re-arms the taken source.
        isv_d     = (isv_q & ~eret_oh) | take_oh;
        pending_d = (pending_q & ~take_oh) | rise;
        mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IC_IDLE: begin
                if (elig_v) state_d = IC_REQ;
            end
            IC_REQ: begin
                if (!elig_v) state_d = isv_v ? IC_BUSY : IC_IDLE;
            end
            IC_BUSY: begin
                if (elig_v) state_d = IC_REQ;
                else if (!isv_v) state_d = IC_IDLE;
            end
            default: state_d = IC_IDLE;
        endcase
        int_req_d  = (state_d == IC_REQ);
        int_vec_d  = elig_v ? elig_idx : int_vec_q;
        int_addr_d = ic_vec_addr(VEC_BASE, VEC_STRIDE, int_vec_d);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            hw_prev_q  <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            isv_q      <= '0;
            int_req_q  <= 1'b0;
            int_vec_q  <= '0;
            int_addr_q <= VEC_BASE;
            state_q    <= IC_IDLE;
        end else begin
            hw_prev_q  <= bus.hw_int;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            isv_q      <= isv_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            int_addr_q <= int_addr_d;
            state_q    <= state_d;
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vec    = int_vec_q;
    assign bus.int_addr   = int_addr_q;
    assign bus.mask       = mask_q;
    assign bus.in_service = isv_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the controller.
module tb_int_ctrl;

    logic clk = 1'b0;
    logic clr_n;
    int checks = 0;
    int failures = 0;

    int_ctrl_if #(.NUM_SRC(8)) bus ();

    int_ctrl #(.NUM_SRC(8)) u_dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0]  m_pend, m_mask, m_isv, m_prev;
    logic        m_req;
    int          m_vec;
    logic [31:0] m_addr;

    function automatic int model_winner();
        int limit;
        limit = 8;
        if (m_isv != 8'h00) begin
`ifdef INT_CTRL_NEST_EN
            for (int i = 7; i >= 0; i--) if (m_isv[i]) limit = i;
`else
            limit = 0;
`endif
        end
        for (int i = 0; i < limit; i++)
            if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        logic [7:0] isv_n, pend_n;
        w = model_winner();
        if (!clr_n) begin
            m_pend = 8'h00; m_mask = 8'hFF; m_isv = 8'h00; m_prev = 8'h00;
            m_req = 1'b0; m_vec = 0; m_addr = 32'h100;
        end else begin
            isv_n = m_isv;
            pend_n = m_pend;
            if (bus.eret && m_isv != 8'h00) isv_n = m_isv & (m_isv - 8'd1);
            if (bus.take && m_req) begin
                isv_n[m_vec] = 1'b1;
                pend_n[m_vec] = 1'b0;
            end
            pend_n = pend_n | (bus.hw_int & ~m_prev);
            if (bus.mask_we) m_mask = bus.mask_wdata;
            m_prev = bus.hw_int;
            m_isv = isv_n;
            m_pend = pend_n;
            m_req = (w >= 0);
            if (w >= 0) m_vec = w;
            m_addr = 32'h100 + 32'(m_vec * 8);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse(input logic [7:0] v);
        bus.hw_int = v;
        tick();
        bus.hw_int = 8'h00;
        tick();
    endtask

    task automatic take_cycle();
        bus.take = 1'b1;
        tick();
        bus.take = 1'b0;
        tick();
    endtask

    task automatic eret_cycle();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        tick();
        tick();
        checks += 6;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", bus.int_req); end
        if (bus.int_vec !== 3'd0) begin failures++; $display("FAIL reset_vec got %0d want 0", bus.int_vec); end
        if (bus.int_addr !== 32'h100) begin failures++; $display("FAIL reset_addr got %h want 00000100", bus.int_addr); end
        if (bus.mask !== 8'hFF) begin failures++; $display("FAIL reset_mask got %h want ff", bus.mask); end
        if (bus.in_service !== 8'h00) begin failures++; $display("FAIL reset_isv got %h want 00", bus.in_service); end
        if (bus.pending !== 8'h00) begin failures++; $display("FAIL reset_pend got %h want 00", bus.pending); end
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.hw_int = 8'h08;
        tick();
        bus.hw_int = 8'h00;
        checks += 2;
        if (bus.pending !== 8'h08) begin failures++; $display("FAIL basic_pend_k got %h want 08", bus.pending); end
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL basic_req_k got %b want 0", bus.int_req); end
        tick();
        checks += 3;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL basic_req got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd3) begin failures++; $display("FAIL basic_vec got %0d want 3", bus.int_vec); end
        if (bus.int_addr !== 32'h118) begin failures++; $display("FAIL basic_addr got %h want 00000118", bus.int_addr); end
        take_cycle();
        checks += 3;
        if (bus.pending !== 8'h00) begin failures++; $display("FAIL basic_pend_take got %h want 00", bus.pending); end
        if (bus.in_service !== 8'h08) begin failures++; $display("FAIL basic_isv got %h want 08", bus.in_service); end
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL basic_req_take got %b want 0", bus.int_req); end
        eret_cycle();
        checks++;
        if (bus.in_service !== 8'h00) begin failures++; $display("FAIL basic_eret got %h want 00", bus.in_service); end
        tick();
    endtask

    task automatic test_priority();
        pulse(8'h24);
        checks += 2;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL prio_req got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd2) begin failures++; $display("FAIL prio_vec got %0d want 2", bus.int_vec); end
        take_cycle();
        checks++;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL prio_low_blocked got %b want 0", bus.int_req); end
        eret_cycle();
        tick();
        checks += 3;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL prio_req5 got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd5) begin failures++; $display("FAIL prio_vec5 got %0d want 5", bus.int_vec); end
        if (bus.int_addr !== 32'h128) begin failures++; $display("FAIL prio_addr5 got %h want 00000128", bus.int_addr); end
        take_cycle();
        eret_cycle();
        tick();
    endtask

    task automatic test_nesting();
        pulse(8'h10);
        take_cycle();
        checks++;
        if (bus.in_service !== 8'h10) begin failures++; $display("FAIL nest_isv4 got %h want 10", bus.in_service); end
        pulse(8'h02);
`ifdef INT_CTRL_NEST_EN
        checks += 2;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL nest_req1 got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd1) begin failures++; $display("FAIL nest_vec1 got %0d want 1", bus.int_vec); end
        take_cycle();
        checks++;
        if (bus.in_service !== 8'h12) begin failures++; $display("FAIL nest_isv12 got %h want 12", bus.in_service); end
        pulse(8'h40);
        checks++;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL nest_req6 got %b want 0", bus.int_req); end
        eret_cycle();
        checks++;
        if (bus.in_service !== 8'h10) begin failures++; $display("FAIL nest_eret1 got %h want 10", bus.in_service); end
        tick();
        checks++;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL nest_req6b got %b want 0", bus.int_req); end
        eret_cycle();
        checks++;
        if (bus.in_service !== 8'h00) begin failures++; $display("FAIL nest_eret2 got %h want 00", bus.in_service); end
        tick();
        checks += 2;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL nest_late6 got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd6) begin failures++; $display("FAIL nest_vec6 got %0d want 6", bus.int_vec); end
`else
        checks++;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL nonest_req1 got %b want 0", bus.int_req); end
        eret_cycle();
        checks++;
        if (bus.in_service !== 8'h00) begin failures++; $display("FAIL nonest_eret got %h want 00", bus.in_service); end
        tick();
        checks += 2;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL nonest_late1 got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd1) begin failures++; $display("FAIL nonest_vec1 got %0d want 1", bus.int_vec); end
`endif
        take_cycle();
        eret_cycle();
        tick();
    endtask

    task automatic test_masking();
        bus.mask_we = 1'b1;
        bus.mask_wdata = 8'hFE;
        tick();
        bus.mask_we = 1'b0;
        pulse(8'h01);
        tick();
        checks += 2;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL mask_blocked got %b want 0", bus.int_req); end
        if (bus.pending !== 8'h01) begin failures++; $display("FAIL mask_retain got %h want 01", bus.pending); end
        bus.mask_we = 1'b1;
        bus.mask_wdata = 8'hFF;
        tick();
        bus.mask_we = 1'b0;
        tick();
        checks += 2;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL mask_unblock got %b want 1", bus.int_req); end
        if (bus.int_vec !== 3'd0) begin failures++; $display("FAIL mask_vec0 got %0d want 0", bus.int_vec); end
        take_cycle();
        eret_cycle();
        tick();
    endtask

    task automatic test_boundary();
        bus.hw_int = 8'h80;
        for (int i = 0; i < 10; i++) tick();
        bus.hw_int = 8'h00;
        tick();
        checks += 2;
        if (bus.pending !== 8'h80) begin failures++; $display("FAIL bnd_level_pend got %h want 80", bus.pending); end
        if (bus.int_vec !== 3'd7) begin failures++; $display("FAIL bnd_vec7 got %0d want 7", bus.int_vec); end
        take_cycle();
        checks++;
        if (bus.pending !== 8'h00) begin failures++; $display("FAIL bnd_one_pend got %h want 00", bus.pending); end
        eret_cycle();
        tick();
        pulse(8'h04);
        bus.take = 1'b1;
        bus.hw_int = 8'h04;
        tick();
        bus.take = 1'b0;
        bus.hw_int = 8'h00;
        checks += 2;
        if (bus.pending !== 8'h04) begin failures++; $display("FAIL bnd_rise_wins got %h want 04", bus.pending); end
        if (bus.in_service !== 8'h04) begin failures++; $display("FAIL bnd_isv2 got %h want 04", bus.in_service); end
        tick();
        eret_cycle();
        tick();
        checks++;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL bnd_rereq got %b want 1", bus.int_req); end
        take_cycle();
        eret_cycle();
        tick();
        eret_cycle();
        checks += 2;
        if (bus.in_service !== 8'h00) begin failures++; $display("FAIL bnd_eret_idle got %h want 00", bus.in_service); end
        if (bus.pending !== 8'h00) begin failures++; $display("FAIL bnd_eret_pend got %h want 00", bus.pending); end
        tick();
        checks++;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL bnd_eret_req got %b want 0", bus.int_req); end
    endtask

    task automatic test_random();
        logic prev_take;
        prev_take = 1'b0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            clr_n = ($urandom_range(0, 499) != 0);
            bus.hw_int = 8'($urandom & $urandom & $urandom);
            bus.take = m_req && !prev_take && ($urandom_range(0, 2) == 0);
            bus.eret = ($urandom_range(0, 9) == 0);
            bus.mask_we = ($urandom_range(0, 19) == 0);
            bus.mask_wdata = 8'($urandom | $urandom);
            prev_take = bus.take;
            tick();
            checks += 4;
            if (bus.int_req !== m_req) begin failures++; $display("FAIL rnd_req @%0d got %b want %b", n, bus.int_req, m_req); end
            if (bus.pending !== m_pend) begin failures++; $display("FAIL rnd_pend @%0d got %h want %h", n, bus.pending, m_pend); end
            if (bus.in_service !== m_isv) begin failures++; $display("FAIL rnd_isv @%0d got %h want %h", n, bus.in_service, m_isv); end
            if (bus.mask !== m_mask) begin failures++; $display("FAIL rnd_mask @%0d got %h want %h", n, bus.mask, m_mask); end
            if (m_req) begin
                checks += 2;
                if (bus.int_vec !== 3'(m_vec)) begin failures++; $display("FAIL rnd_vec @%0d got %0d want %0d", n, bus.int_vec, m_vec); end
                if (bus.int_addr !== m_addr) begin failures++; $display("FAIL rnd_addr @%0d got %h want %h", n, bus.int_addr, m_addr); end
            end
        end
        clr_n = 1'b1;
        bus.hw_int = 8'h00;
        bus.take = 1'b0;
        bus.eret = 1'b0;
        bus.mask_we = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(8'h21);
        bus.take = 1'b1;
        tick();
        bus.take = 1'b0;
        checks += 2;
        if (bus.int_req !== 1'b1) begin failures++; $display("FAIL mid_req got %b want 1", bus.int_req); end
        if (bus.in_service !== 8'h01) begin failures++; $display("FAIL mid_isv got %h want 01", bus.in_service); end
        clr_n = 1'b0;
        tick();
        checks += 6;
        if (bus.int_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req got %b want 0", bus.int_req); end
        if (bus.int_vec !== 3'd0) begin failures++; $display("FAIL mid_rst_vec got %0d want 0", bus.int_vec); end
        if (bus.int_addr !== 32'h100) begin failures++; $display("FAIL mid_rst_addr got %h want 00000100", bus.int_addr); end
        if (bus.mask !== 8'hFF) begin failures++; $display("FAIL mid_rst_mask got %h want ff", bus.mask); end
        if (bus.in_service !== 8'h00) begin failures++; $display("FAIL mid_rst_isv got %h want 00", bus.in_service); end
        if (bus.pending !== 8'h00) begin failures++; $display("FAIL mid_rst_pend got %h want 00", bus.pending); end
        clr_n = 1'b1;
        tick();
    endtask

    initial begin
        clr_n = 1'b0;
        bus.hw_int = 8'h00;
        bus.mask_we = 1'b0;
        bus.mask_wdata = 8'h00;
        bus.take = 1'b0;
        bus.eret = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_masking();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Vectored hardware-interrupt controller that sits between the `hardware_interrupt` pins and cp0. It latches edges on up to `NUM_SRC` sources, applies a software-writable mask, and picks the highest-priority eligible source. It presents cp0 with a single request plus a handler address, and tracks in-service sources so that `eret` retires them in priority order.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, 1..8.
- `VEC_BASE`, default 32'h0000_0100: word address of the source-0 handler.
- `VEC_STRIDE`, default 32'h0000_0008: word distance between consecutive handlers.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `clr_n`, input, 1: reset, synchronous, active-low.
- `hw_int`, input, NUM_SRC: raw interrupt lines, already synchronous to `clk`.
- `mask_we`, input, 1: write-enable for the mask register.
- `mask_wdata`, input, NUM_SRC: new mask; 1 = source enabled.
- `take`, input, 1: one-cycle pulse from cp0 when it jumps to `int_addr`.
- `eret`, input, 1: one-cycle pulse when the CPU executes eret.
- `int_req`, output, 1: an eligible interrupt is outstanding (registered).
- `int_vec`, output, 3: index of the requesting source (registered).
- `int_addr`, output, 32: `VEC_BASE + int_vec*VEC_STRIDE` (registered).
- `mask`, output, NUM_SRC: current mask register.
- `in_service`, output, NUM_SRC: sources whose handlers are active.
- `pending`, output, NUM_SRC: latched, not yet taken requests.

## Operation
- **Edge detect.** `hw_prev` holds last-cycle `hw_int`. A source sees a rise when `hw_int[i] & ~hw_prev[i]`. A rise sets `pending[i]`. Level-held lines do not re-trigger.
- **Priority.** Fixed priority; index 0 is highest.
  - `eligible = pending & mask`, restricted to sources of strictly higher priority than the highest set `in_service` bit.
  - When `in_service` is all zero, every pending, unmasked source is eligible.
- **State machine.**
  - IDLE: `in_service` is 0 and there is no request.
  - REQ: `int_req`=1.
  - BUSY: `in_service` is nonzero and there is no eligible source.
  - IDLE→REQ when eligible is nonzero.
  - REQ→BUSY on `take` if no further eligible source remains. Otherwise REQ→REQ with the next winner.
  - BUSY→REQ when an eligible source appears, including after an `eret` lowers the service level.
  - BUSY→IDLE when `eret` clears the last `in_service` bit.
- **Take.** On `take` with `int_req`=1:
  - set `in_service[int_vec]`;
  - clear `pending[int_vec]`.
  - `take` while `int_req`=0 is ignored.
- **Eret.** On `eret`, clear the highest-priority set `in_service` bit. `eret` with `in_service`=0 is ignored.
- **Mask write.** Takes effect at the next edge. Masking the current winner drops or retargets `int_req` one cycle later. `pending` bits of masked sources are retained.
- **Simultaneous events, same cycle.**
  - `eret` is applied before `take`.
  - `take` clearing `pending[i]` combined with a new rise on `i`: the rise wins and `pending[i]` stays 1.
  - `mask_we` together with `take`: the take uses the old `int_vec`.

## Timing
- Reset (`clr_n`=0 at an edge) sets: `int_req`=0, `int_vec`=0, `int_addr`=`VEC_BASE`, `mask`=all-ones, `in_service`=0, `pending`=0, `hw_prev`=0, FSM=IDLE.
- Reset mid-request drops everything; an outstanding `take` is lost.
- Latency:
  - A rise visible at edge k sets `pending` at edge k.
  - `int_req`, `int_vec` and `int_addr` become valid after edge k+1 (two-edge rise-to-request).
- `take` at edge t: `int_req` reflects the next winner (or 0) after edge t+1. Between t and t+1, `int_req` is stale, and cp0 must not issue another `take` in the cycle right after a `take`.
- `int_addr` arithmetic is 32-bit with truncation on overflow.

## Configuration
- `INT_CTRL_NEST_EN` defined: nesting as described; a higher-priority source may preempt an active handler.
- `INT_CTRL_NEST_EN` undefined:
  - eligible is forced to 0 while any `in_service` bit is set;
  - at most one `in_service` bit is ever set;
  - `eret` clears it.

## Structure
- Package `int_ctrl_pkg` holds:
  - the FSM state enum (`IC_IDLE`, `IC_REQ`, `IC_BUSY`);
  - `IC_VEC_W`=3;
  - the default `VEC_BASE`/`VEC_STRIDE` constants.
- Sub-module `prio_enc`: a parameterized lowest-index-first priority encoder producing a valid bit and an index. It is instantiated twice, once for eligible and once for `in_service`.

## Test plan
- **Basic request.** Reset, then pulse `hw_int[3]`. Expect `int_req`=1, `int_vec`=3 and `int_addr`=32'h118 two edges later. After `take`, expect `pending[3]`=0, `in_service`=8'h08 and `int_req`=0.
- **Priority.** Raise sources 5 and 2 in the same cycle → vec 2 first. After `take` → vec 5 is not requested (lower priority). After `eret` → vec 5, addr 32'h128.
- **Nesting (NEST_EN).** With source 4 in service, raise source 1 → `int_req` with vec 1. Raise source 6 → no request. `eret` twice → `in_service` goes 8'h12→8'h10→8'h00.
- **Masking.** Write mask=8'hFE, then pulse source 0 → no request. Write mask=8'hFF → `int_req`=1, vec 0, one edge after the write.
- **Boundary.** Hold `hw_int[7]` high for 10 cycles → exactly one pending. A rise on source 2 in the same cycle as `take` of source 2 → `pending[2]` stays 1. `eret` with nothing in service → no change.
- **Reset mid-operation.** Drop `clr_n` while `int_req`=1 and `in_service`=8'h01 → all outputs at reset values on the next edge.
